// File: rtl/button_event_queue_if.sv
// Consumer-side event handshake for button_event_queue.
// The queue drives valid/id/press from its FIFO head and the consumer drives ready.
interface button_event_queue_if #(
  parameter int id_width = 2
) ();

  logic                event_valid;
  logic                event_ready;
  logic [id_width-1:0] event_id;
  logic                event_press;

  // The queue presents events.
  modport master (
    output event_valid,
    output event_id,
    output event_press,
    input  event_ready
  );

  // The consumer (CPU/MMIO side) accepts events.
  modport slave (
    input  event_valid,
    input  event_id,
    input  event_press,
    output event_ready
  );

endinterface

// File: rtl/button_event_queue.sv
// button_event_queue
//   Turns debounced button levels into a stream of discrete button events.
//   Each channel's rising edge raises a pending request. A round-robin arbiter
//   moves at most one request per cycle into a small first-word-fall-through
//   FIFO, and the FIFO head is offered to one consumer over valid/ready.
//   The sticky 'dropped' flag records any edge that had to be coalesced
//   because an earlier edge on the same channel was still pending.
//
// Optional build macro:
//   BUTTON_RELEASE_EVENTS_EN - also queue release (falling-edge) events, which
//   carry event_press = 0. Left undefined, only press events are produced and
//   event_press is always 1.
module button_event_queue #(
  parameter int width      = 4,
  parameter int fifo_depth = 4,
  parameter int id_width   = (width > 1) ? $clog2(width) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [width-1:0]      debounced_signal,
  button_event_queue_if.master  evt,
  output logic                  dropped,
  input  logic                  dropped_clear
);

  localparam int addr_w = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int cnt_w  = $clog2(fifo_depth + 1);

  typedef struct packed {
    logic                press;
    logic [id_width-1:0] id;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Edge detection and pending requests
  // ---------------------------------------------------------------------------
  logic [width-1:0]    prev;
  logic [width-1:0]    rise;
  logic [width-1:0]    pend_p;
  logic [width-1:0]    clr_p;
  logic [width-1:0]    coal_p;
  logic [width-1:0]    req;

  logic                grant;
  logic                gnt_hit;
  logic [id_width-1:0] gnt_id;
  logic                gnt_press;
  logic [id_width-1:0] rr_ptr;

  logic                full;
  logic                any_coalesce;

  assign rise = debounced_signal & ~prev;

`ifdef BUTTON_RELEASE_EVENTS_EN
  logic [width-1:0] fall;
  logic [width-1:0] pend_r;
  logic [width-1:0] clr_r;
  logic [width-1:0] coal_r;

  assign fall = ~debounced_signal & prev;
  assign req  = pend_p | pend_r;
  // Press has priority inside a granted channel; release goes on a later grant.
  assign gnt_press = pend_p[gnt_id];
`else
  assign req       = pend_p;
  assign gnt_press = 1'b1;
`endif

  // Grant-clear vectors and coalesce detection for the pending bits.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    clr_p = '0;
    if (grant && gnt_press) clr_p[gnt_id] = 1'b1;
    // A set on a still-pending, ungranted bit merges two edges into one event.
    coal_p = rise & pend_p & ~clr_p;
  end

`ifdef BUTTON_RELEASE_EVENTS_EN
  // Same grant-clear and coalesce rules for the release vector.
  always_comb begin
    clr_r = '0;
    if (grant && !gnt_press) clr_r[gnt_id] = 1'b1;
    coal_r = fall & pend_r & ~clr_r;
  end

  assign any_coalesce = |coal_p || |coal_r;
`else
  assign any_coalesce = |coal_p;
`endif

  // Level history and press-pending bits; a set in the grant cycle wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev   <= '0;
      pend_p <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      prev   <= debounced_signal;
      pend_p <= rise | (pend_p & ~clr_p);
    end
  end

`ifdef BUTTON_RELEASE_EVENTS_EN
  // Release-pending bits, same set-wins rule as the press bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_r <= '0;
    end else begin
      pend_r <= fall | (pend_r & ~clr_r);
    end
  end
`endif

  // Sticky drop flag; a new coalesce outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dropped <= 1'b0;
    end else if (any_coalesce) begin
      dropped <= 1'b1;
    end else if (dropped_clear) begin
      dropped <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  // ---------------------------------------------------------------------------
  // First requesting channel at or after rr_ptr, wrapping at width.
  always_comb begin
    int idx;
    gnt_hit = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = 0; k < width; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= width) idx = idx - width;
      if (!gnt_hit && req[idx]) begin
        gnt_hit = 1'b1;
        gnt_id  = id_width'(idx);
      end
    end
  end

  assign grant = gnt_hit && !full;

  // Search start moves just past the winner; it holds when nothing is granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (gnt_id == id_width'(width - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  entry_t              mem [fifo_depth];
  logic [addr_w-1:0]   wr_ptr;
  logic [addr_w-1:0]   rd_ptr;
  logic [cnt_w-1:0]    count;
  logic                wr_en;
  logic                rd_en;
  entry_t              wr_entry;
  entry_t              head;

  assign full     = (count == cnt_w'(fifo_depth));
  assign wr_en    = grant;
  assign rd_en    = (count != '0) && evt.event_ready;
  assign wr_entry = '{press: gnt_press, id: gnt_id};

  // Storage array written on each grant.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; only the pointers and count do,
    // and the outputs are masked while the FIFO is empty.
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + addr_w'(1);
      if (rd_en) rd_ptr <= rd_ptr + addr_w'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
    end
  end

  // Head drives the consumer directly; idle values are id=0, press=1.
  always_comb begin
    head             = mem[rd_ptr];
    evt.event_valid  = (count != '0);
    evt.event_id     = evt.event_valid ? head.id : '0;
    evt.event_press  = evt.event_valid ? head.press : 1'b1;
  end

endmodule

// File: tb/tb_button_event_queue.sv
// Bench for button_event_queue (width=8, fifo_depth=4).
// Directed stimulus pushes the expected events into a scoreboard queue; a
// monitor on the falling clock edge pops and compares every accepted event.
// Expectations for release events are added when BUTTON_RELEASE_EVENTS_EN is set.
module tb_button_event_queue;

  localparam int width      = 8;
  localparam int fifo_depth = 4;
  localparam int id_width   = 3;

  typedef struct packed {
    logic [id_width-1:0] id;
    logic                press;
  } exp_t;

  logic             clk;
  logic             reset_n;
  logic [width-1:0] debounced_signal;
  logic             dropped;
  logic             dropped_clear;

  button_event_queue_if #(.id_width(id_width)) ev ();

  button_event_queue #(
    .width      (width),
    .fifo_depth (fifo_depth),
    .id_width   (id_width)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .debounced_signal (debounced_signal),
    .evt              (ev),
    .dropped          (dropped),
    .dropped_clear    (dropped_clear)
  );

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input bit press);
    exp_t e;
    e.id    = id_width'(id);
    e.press = press;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    debounced_signal = '0;
    dropped_clear    = 1'b0;
    ev.event_ready   = 1'b0;
    reset_n          = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  // Scoreboard monitor: each accepted handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && ev.event_valid && ev.event_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_event: got id %0d press %0d, expected none (t=%0t)",
                 ev.event_id, ev.event_press, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("evt_id", int'(ev.event_id), int'(e.id));
        check("evt_press", int'(ev.event_press), int'(e.press));
      end
    end
  end

  initial begin
    debounced_signal = '0;
    dropped_clear    = 1'b0;
    ev.event_ready   = 1'b0;
    reset_n          = 1'b0;
    tick(1);

    // Reset state.
    check("rst_valid", int'(ev.event_valid), 0);
    check("rst_id", int'(ev.event_id), 0);
    check("rst_press", int'(ev.event_press), 1);
    check("rst_dropped", int'(dropped), 0);
    reset_n = 1'b1;
    tick(1);

    // Test 1: single press on ch2, two-cycle latency, one pop, no repeat.
    do_reset();
    push(2, 1'b1);
    debounced_signal[2] = 1'b1;
    tick(1);
    check("t1_valid_n1", int'(ev.event_valid), 0);
    tick(1);
    check("t1_valid_n2", int'(ev.event_valid), 1);
    check("t1_id", int'(ev.event_id), 2);
    check("t1_press", int'(ev.event_press), 1);
    ev.event_ready = 1'b1;
    tick(1);
    ev.event_ready = 1'b0;
    check("t1_valid_after_pop", int'(ev.event_valid), 0);
    tick(5);
    check("t1_no_repeat", int'(ev.event_valid), 0);
    check("t1_empty", exp_q.size(), 0);

    // Test 2: four simultaneous rises drain 0..3 on consecutive cycles, twice.
    do_reset();
    ev.event_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(i, 1'b1);
    debounced_signal[3:0] = 4'b1111;
    tick(6);
    check("t2_burst1_done", exp_q.size(), 0);
    check("t2_idle1", int'(ev.event_valid), 0);
`ifdef BUTTON_RELEASE_EVENTS_EN
    for (int i = 0; i < 4; i++) push(i, 1'b0);
`endif
    debounced_signal[3:0] = 4'b0000;
    tick(8);
    for (int i = 0; i < 4; i++) push(i, 1'b1);
    debounced_signal[3:0] = 4'b1111;
    tick(6);
    check("t2_burst2_done", exp_q.size(), 0);
    check("t2_idle2", int'(ev.event_valid), 0);

    // Test 3: five rises into a depth-4 FIFO; the fifth waits, then follows a pop.
    do_reset();
    for (int i = 0; i < 5; i++) push(i, 1'b1);
    debounced_signal[4:0] = 5'b11111;
    tick(7);
    check("t3_valid_full", int'(ev.event_valid), 1);
    check("t3_head0", int'(ev.event_id), 0);
    check("t3_no_drop", int'(dropped), 0);
    check("t3_queued", exp_q.size(), 5);
    ev.event_ready = 1'b1;
    tick(1);
    ev.event_ready = 1'b0;
    tick(1);
    check("t3_head1", int'(ev.event_id), 1);
    ev.event_ready = 1'b1;
    tick(6);
    check("t3_empty", exp_q.size(), 0);
    check("t3_idle", int'(ev.event_valid), 0);

    // Test 4: coalescing while full sets dropped; clear works unless a new drop coincides.
    do_reset();
    for (int i = 4; i < 8; i++) push(i, 1'b1);
    debounced_signal[7:4] = 4'b1111;
    tick(7);
    debounced_signal[1] = 1'b1;
    tick(2);
    debounced_signal[1] = 1'b0;
    tick(2);
    check("t4_no_drop_yet", int'(dropped), 0);
    debounced_signal[1] = 1'b1;
    tick(2);
    check("t4_dropped", int'(dropped), 1);
    dropped_clear = 1'b1;
    tick(1);
    dropped_clear = 1'b0;
    check("t4_cleared", int'(dropped), 0);
    debounced_signal[2] = 1'b1;
    tick(2);
    debounced_signal[2] = 1'b0;
    tick(2);
    debounced_signal[2] = 1'b1;
    dropped_clear       = 1'b1;
    tick(1);
    dropped_clear = 1'b0;
    check("t4_set_beats_clear", int'(dropped), 1);
    push(1, 1'b1);
    push(2, 1'b1);
`ifdef BUTTON_RELEASE_EVENTS_EN
    push(1, 1'b0);
    push(2, 1'b0);
`endif
    ev.event_ready = 1'b1;
    tick(12);
    check("t4_empty", exp_q.size(), 0);

    // Test 5: reset while three entries are queued and ch0 is held.
    do_reset();
    debounced_signal[2:0] = 3'b111;
    tick(6);
    check("t5_queued_valid", int'(ev.event_valid), 1);
    reset_n = 1'b0;
    debounced_signal = 8'b0000_0001;
    #1;
    check("t5_rst_valid", int'(ev.event_valid), 0);
    check("t5_rst_id", int'(ev.event_id), 0);
    check("t5_rst_press", int'(ev.event_press), 1);
    tick(2);
    reset_n = 1'b1;
    push(0, 1'b1);
    tick(1);
    check("t5_valid_n1", int'(ev.event_valid), 0);
    tick(1);
    check("t5_valid_n2", int'(ev.event_valid), 1);
    check("t5_id", int'(ev.event_id), 0);
    ev.event_ready = 1'b1;
    tick(3);
    check("t5_empty", exp_q.size(), 0);

    // Test 6: ch3 press then release five cycles later.
    do_reset();
    ev.event_ready = 1'b1;
    push(3, 1'b1);
    debounced_signal[3] = 1'b1;
    tick(5);
`ifdef BUTTON_RELEASE_EVENTS_EN
    push(3, 1'b0);
`endif
    debounced_signal[3] = 1'b0;
    tick(6);
    check("t6_empty", exp_q.size(), 0);
    check("t6_idle", int'(ev.event_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
